// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle datapath.
// Sequences fetch, decode, execute, memory and writeback for each instruction.
// It drives the ALU decoder's aluop, the datapath enables and the mux selects,
// and it stalls on the memory ready handshake. Outputs are decoded from the
// state. The exceptions are irwrite and pc_en, which are also gated by
// mem_ready in FETCH and by zero in BRANCH. While reset is high, every output
// is held at 0.

module multicycle_ctrl #(
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           mem_ready,
    output logic [1:0]     aluop,
    output logic           mem_req,
    output logic           memwrite,
    output logic           irwrite,
    output logic           pc_en,
    output logic           regwrite,
    output logic           adrsrc,
    output logic [1:0]     alusrca,
    output logic [1:0]     alusrcb,
    output logic [1:0]     resultsrc,
    output logic           halted,
    output logic           illegal,
    output logic [3:0]     state_dbg
);

    // State encodings are visible on state_dbg, so they are fixed explicitly.
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC_R  = 4'd6,
        EXEC_I  = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10,
        HALT    = 4'd11,
        ILLEGAL = 4'd12
    } state_t;

    // Instruction classes recognised in DECODE.
    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BEQ,
        CLS_JUMP,
        CLS_HALT,
        CLS_BAD
    } op_class_t;

    // Full-width opcodes for the non-ALU classes.
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_STORE = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(5'b11000);
    localparam logic [OPW-1:0] OP_JUMP  = OPW'(5'b11001);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(5'b11111);

    // aluop codes understood by the ALU decoder.
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    // ALU operand A select.
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_REG_A  = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SRCB_REG_B = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_ONE   = 2'b10;

    // Result bus select.
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    state_t    state;
    state_t    state_next;
    op_class_t op_class;

    // Raw state-decoded outputs. The reset gate is applied after this stage.
    logic [1:0] aluop_raw;
    logic       mem_req_raw;
    logic       memwrite_raw;
    logic       irwrite_raw;
    logic       pc_en_raw;
    logic       regwrite_raw;
    logic       adrsrc_raw;
    logic [1:0] alusrca_raw;
    logic [1:0] alusrcb_raw;
    logic [1:0] resultsrc_raw;
    logic       halted_raw;
    logic       illegal_raw;

    // Classify the opcode. The top two bits alone identify the ALU classes.
    always_comb begin
        op_class = CLS_BAD;
        if (op[OPW-1 -: 2] == 2'b00) begin
            op_class = CLS_R;
        end else if (op[OPW-1 -: 2] == 2'b01) begin
            op_class = CLS_I;
        end else if (op == OP_LOAD || op == OP_STORE) begin
            op_class = CLS_MEM;
        end else if (op == OP_BEQ) begin
            op_class = CLS_BEQ;
        end else if (op == OP_JUMP) begin
            op_class = CLS_JUMP;
        end else if (op == OP_HALT) begin
            op_class = CLS_HALT;
        end
    end

    // State register. Reset returns to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next    = state;
        aluop_raw     = ALUOP_ADD;
        mem_req_raw   = 1'b0;
        memwrite_raw  = 1'b0;
        irwrite_raw   = 1'b0;
        pc_en_raw     = 1'b0;
        regwrite_raw  = 1'b0;
        adrsrc_raw    = 1'b0;
        alusrca_raw   = SRCA_PC;
        alusrcb_raw   = SRCB_REG_B;
        resultsrc_raw = RES_ALUOUT;
        halted_raw    = 1'b0;
        illegal_raw   = 1'b0;

        unique case (state)
            FETCH: begin
                // Fetch the word at PC and compute PC+1 in the same access.
                mem_req_raw   = 1'b1;
                adrsrc_raw    = 1'b0;
                alusrca_raw   = SRCA_PC;
                alusrcb_raw   = SRCB_ONE;
                aluop_raw     = ALUOP_ADD;
                resultsrc_raw = RES_ALU;
                irwrite_raw   = mem_ready;
                pc_en_raw     = mem_ready;
                if (mem_ready) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                // Precompute the branch target while the register file is read.
                alusrca_raw = SRCA_OLD_PC;
                alusrcb_raw = SRCB_IMM;
                aluop_raw   = ALUOP_ADD;
                unique case (op_class)
                    CLS_R:    state_next = EXEC_R;
                    CLS_I:    state_next = EXEC_I;
                    CLS_MEM:  state_next = MEMADR;
                    CLS_BEQ:  state_next = BRANCH;
                    CLS_JUMP: state_next = JUMP;
                    CLS_HALT: state_next = HALT;
                    default:  state_next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                // Compute the effective address. op[0] separates store from load.
                alusrca_raw = SRCA_REG_A;
                alusrcb_raw = SRCB_IMM;
                aluop_raw   = ALUOP_ADD;
                state_next  = op[0] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req_raw = 1'b1;
                adrsrc_raw  = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                regwrite_raw  = 1'b1;
                resultsrc_raw = RES_MEM;
                state_next    = FETCH;
            end
            MEMWR: begin
                mem_req_raw  = 1'b1;
                memwrite_raw = 1'b1;
                adrsrc_raw   = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end
            end
            EXEC_R: begin
                alusrca_raw = SRCA_REG_A;
                alusrcb_raw = SRCB_REG_B;
                aluop_raw   = ALUOP_FN;
                state_next  = ALUWB;
            end
            EXEC_I: begin
                alusrca_raw = SRCA_REG_A;
                alusrcb_raw = SRCB_IMM;
                aluop_raw   = ALUOP_FN;
                state_next  = ALUWB;
            end
            ALUWB: begin
                regwrite_raw  = 1'b1;
                resultsrc_raw = RES_ALUOUT;
                state_next    = FETCH;
            end
            BRANCH: begin
                // Compare the registers. The precomputed target is loaded only when they are equal.
                alusrca_raw   = SRCA_REG_A;
                alusrcb_raw   = SRCB_REG_B;
                aluop_raw     = ALUOP_SUB;
                resultsrc_raw = RES_ALUOUT;
                pc_en_raw     = zero;
                state_next    = FETCH;
            end
            JUMP: begin
                resultsrc_raw = RES_ALUOUT;
                pc_en_raw     = 1'b1;
                state_next    = FETCH;
            end
            HALT: begin
                halted_raw = 1'b1;
            end
            ILLEGAL: begin
                illegal_raw = 1'b1;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Force every output low while reset is held. This drops a pending memory request at once.
    always_comb begin
        if (reset) begin
            aluop     = 2'b00;
            mem_req   = 1'b0;
            memwrite  = 1'b0;
            irwrite   = 1'b0;
            pc_en     = 1'b0;
            regwrite  = 1'b0;
            adrsrc    = 1'b0;
            alusrca   = 2'b00;
            alusrcb   = 2'b00;
            resultsrc = 2'b00;
            halted    = 1'b0;
            illegal   = 1'b0;
            state_dbg = 4'd0;
        end else begin
            aluop     = aluop_raw;
            mem_req   = mem_req_raw;
            memwrite  = memwrite_raw & mem_req_raw;
            irwrite   = irwrite_raw;
            pc_en     = pc_en_raw;
            regwrite  = regwrite_raw;
            adrsrc    = adrsrc_raw;
            alusrca   = alusrca_raw;
            alusrcb   = alusrcb_raw;
            resultsrc = resultsrc_raw;
            halted    = halted_raw;
            illegal   = illegal_raw;
            state_dbg = state;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// It runs table-driven instruction vectors, hand-written multi-cycle sequences
// and a randomized run. The randomized run is checked against an
// instruction-level phase-queue model.

module tb_multicycle_ctrl;

    typedef struct packed {
        logic [1:0] aluop;
        logic       mem_req;
        logic       memwrite;
        logic       irwrite;
        logic       pc_en;
        logic       regwrite;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic       halted;
        logic       illegal;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        logic [4:0] op;
        logic       z;
        int         cycles;
        int         regwrites;
        int         memwrites;
        int         pc_loads;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] op = 5'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [1:0] aluop;
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pc_en;
    logic       regwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       halted;
    logic       illegal;
    logic [3:0] state_dbg;
    outs_t      act;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl #(.OPW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .aluop     (aluop),
        .mem_req   (mem_req),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .pc_en     (pc_en),
        .regwrite  (regwrite),
        .adrsrc    (adrsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .resultsrc (resultsrc),
        .halted    (halted),
        .illegal   (illegal),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    assign act = {aluop, mem_req, memwrite, irwrite, pc_en, regwrite, adrsrc,
                  alusrca, alusrcb, resultsrc, halted, illegal, state_dbg};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Expected outputs for one control phase, listed from the per-state behaviour.
    function automatic outs_t model_outs(input int ph, input logic mr, input logic z);
        outs_t o = '0;
        o.state = 4'(ph);
        case (ph)
            0: begin
                o.mem_req = 1'b1; o.alusrcb = 2'b10; o.resultsrc = 2'b10;
                o.irwrite = mr;   o.pc_en = mr;
            end
            1:  begin o.alusrca = 2'b01; o.alusrcb = 2'b01; end
            2:  begin o.alusrca = 2'b10; o.alusrcb = 2'b01; end
            3:  begin o.mem_req = 1'b1; o.adrsrc = 1'b1; end
            4:  begin o.regwrite = 1'b1; o.resultsrc = 2'b01; end
            5:  begin o.mem_req = 1'b1; o.memwrite = 1'b1; o.adrsrc = 1'b1; end
            6:  begin o.alusrca = 2'b10; o.aluop = 2'b10; end
            7:  begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.aluop = 2'b10; end
            8:  o.regwrite = 1'b1;
            9:  begin o.alusrca = 2'b10; o.aluop = 2'b01; o.pc_en = z; end
            10: o.pc_en = 1'b1;
            11: o.halted = 1'b1;
            12: o.illegal = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // The phases an instruction passes through when memory never stalls.
    int q[$];

    task automatic push_instr(input logic [4:0] o);
        q.push_back(0);
        q.push_back(1);
        if (o[4:3] == 2'b00)      begin q.push_back(6); q.push_back(8); end
        else if (o[4:3] == 2'b01) begin q.push_back(7); q.push_back(8); end
        else if (o == 5'b10000)   begin q.push_back(2); q.push_back(3); q.push_back(4); end
        else if (o == 5'b10001)   begin q.push_back(2); q.push_back(5); end
        else if (o == 5'b11000)   q.push_back(9);
        else if (o == 5'b11001)   q.push_back(10);
        else if (o == 5'b11111)   q.push_back(11);
        else                      q.push_back(12);
    endtask

    function automatic logic [4:0] rand_op();
        int r = $urandom_range(0, 39);
        if (r < 8)  return {2'b00, 3'($urandom)};
        if (r < 16) return {2'b01, 3'($urandom)};
        if (r < 22) return 5'b10000;
        if (r < 28) return 5'b10001;
        if (r < 33) return 5'b11000;
        if (r < 37) return 5'b11001;
        if (r < 38) return 5'b11111;
        case ($urandom_range(0, 3))
            0: return 5'b10010;
            1: return 5'b10110;
            2: return 5'b11010;
            default: return 5'b11110;
        endcase
    endfunction

    // Pulse reset and leave the bench just after a rising edge, with the DUT in FETCH.
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Run one instruction with mem_ready held high and tally its cycles and strobes.
    task automatic run_instr(input logic [4:0] o, input logic z,
                             output int cyc, output int rw, output int mw, output int pl);
        cyc = 0; rw = 0; mw = 0; pl = 0;
        forever begin
            @(negedge clk);
            op = o; zero = z; mem_ready = 1'b1;
            #1;
            if ((cyc > 0 && state_dbg == 4'd0) || cyc >= 20) break;
            rw += int'(regwrite);
            mw += int'(memwrite & mem_req);
            pl += int'(pc_en);
            cyc++;
        end
    endtask

    vec_t vecs[7];
    int   ld_state[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
    logic ld_ready[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected the bench to finish first");
        $fatal(1, "watchdog");
    end

    initial begin
        int    cyc, rw, mw, pl, cnt_a, cnt_b, term_cnt, ph;
        logic [4:0] cur_op;
        outs_t exp_o;

        vecs[0] = '{5'b00011, 1'b0, 4, 1, 0, 1};
        vecs[1] = '{5'b01010, 1'b0, 4, 1, 0, 1};
        vecs[2] = '{5'b10000, 1'b0, 5, 1, 0, 1};
        vecs[3] = '{5'b10001, 1'b0, 4, 0, 1, 1};
        vecs[4] = '{5'b11000, 1'b1, 3, 0, 0, 2};
        vecs[5] = '{5'b11000, 1'b0, 3, 0, 0, 1};
        vecs[6] = '{5'b11001, 1'b0, 3, 0, 0, 2};

        // Reset state: every output is low while reset is held, even with mem_ready high.
        @(negedge clk);
        #1 check("reset outputs", 32'(act), 32'd0);
        apply_reset();
        @(negedge clk);
        #1;
        check("post-reset state", 32'(state_dbg), 32'd0);
        check("post-reset mem_req", 32'(mem_req), 32'd1);
        check("post-reset irwrite", 32'(irwrite), 32'd1);

        // Table-driven instruction latency and strobe counts, with mem_ready tied high.
        foreach (vecs[i]) begin
            apply_reset();
            run_instr(vecs[i].op, vecs[i].z, cyc, rw, mw, pl);
            check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            check($sformatf("vec%0d regwrite", i), 32'(rw), 32'(vecs[i].regwrites));
            check($sformatf("vec%0d memwrite", i), 32'(mw), 32'(vecs[i].memwrites));
            check($sformatf("vec%0d pc_en", i), 32'(pl), 32'(vecs[i].pc_loads));
        end

        // Load with two memory wait cycles in MEMRD.
        apply_reset();
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            op = 5'b10000; mem_ready = ld_ready[i];
            #1;
            check($sformatf("load wait state %0d", i), 32'(state_dbg), 32'(ld_state[i]));
            cnt_a += int'(mem_req & adrsrc);
            cnt_b += int'(regwrite && resultsrc == 2'b01);
        end
        check("load wait mem_req/adrsrc cycles", 32'(cnt_a), 32'd3);
        check("load wait writeback cycles", 32'(cnt_b), 32'd1);

        // Reset pulse in the middle of a stalled store.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op = 5'b10001; mem_ready = (i == 0);
            #1;
        end
        check("memwr state", 32'(state_dbg), 32'd5);
        check("memwr mem_req", 32'(mem_req), 32'd1);
        check("memwr memwrite", 32'(memwrite), 32'd1);
        #1 reset = 1'b1;
        #1 check("mid-cycle reset outputs", 32'(act), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after release state", 32'(state_dbg), 32'd0);
        check("after release mem_req", 32'(mem_req), 32'd1);

        // An undefined opcode sets a sticky illegal flag.
        apply_reset();
        @(negedge clk); op = 5'b10110; mem_ready = 1'b1; #1;
        @(negedge clk); #1;
        check("illegal at decode", 32'(illegal), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op = 5'($urandom); mem_ready = 1'($urandom);
            #1;
            check($sformatf("illegal sticky %0d", i), 32'({illegal, halted, state_dbg}), {26'd0, 2'b10, 4'd12});
        end
        apply_reset();
        check("illegal cleared", 32'(illegal), 32'd0);

        // A halt sets a sticky halted flag and stops all memory requests.
        @(negedge clk); op = 5'b11111; mem_ready = 1'b1; #1;
        @(negedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op = 5'($urandom); mem_ready = 1'($urandom);
            #1;
            check($sformatf("halt sticky %0d", i), 32'({halted, mem_req}), 32'b10);
        end
        apply_reset();
        check("halted cleared", 32'(halted), 32'd0);

        // Randomized run checked against the phase-queue model.
        apply_reset();
        q.delete();
        term_cnt = 0;
        cur_op = 5'd0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (q.size() == 0) begin
                cur_op = rand_op();
                push_instr(cur_op);
            end
            ph = q[0];
            mem_ready = 1'($urandom);
            zero = 1'($urandom);
            op = (ph == 1 || ph == 2) ? cur_op : 5'($urandom);
            #1;
            exp_o = model_outs(ph, mem_ready, zero);
            check($sformatf("rand cycle %0d", c), 32'(act), 32'(exp_o));
            if (ph == 11 || ph == 12) begin
                term_cnt++;
                if (term_cnt >= 3) begin
                    apply_reset();
                    q.delete();
                    term_cnt = 0;
                end
            end else if (!((ph == 0 || ph == 3 || ph == 5) && !mem_ready)) begin
                void'(q.pop_front());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
